// File: rtl/out_match_checker.sv
// rtl/out_match_checker.sv - lockstep output checker between an undelayed and a delayed copy
// Undelayed outputs queue in a small scoreboard; delayed outputs are compared against its head.
module out_match_checker #(
  parameter int NUM_REQS = 2,
  parameter int WIDTH    = 8,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_REQS-1:0]           pop0,
  input  logic [NUM_REQS-1:0]           pop1,
  input  logic [WIDTH-1:0]              data_out0,
  input  logic [WIDTH-1:0]              data_out1,
  output logic                          prop_ok,
  output logic                          mismatch,
  output logic                          underflow,
  output logic                          overflow,
  output logic [$clog2(SB_DEPTH+1)-1:0] occupancy
);

  localparam int ENTRY_W = NUM_REQS + WIDTH;
  localparam int PTR_W   = $clog2(SB_DEPTH);
  localparam int OCC_W   = $clog2(SB_DEPTH + 1);

  logic [ENTRY_W-1:0] sb_mem [SB_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [OCC_W-1:0]   occ;

  logic               ev0;
  logic               ev1;
  logic               sb_empty;
  logic               sb_full;
  logic               do_push;
  logic               do_pop;
  logic               do_cmp;
  logic               set_underflow;
  logic               set_overflow;
  logic [ENTRY_W-1:0] entry0;
  logic [ENTRY_W-1:0] entry1;
  logic [ENTRY_W-1:0] cmp_ref;

  assign ev0      = start & (|pop0);
  assign ev1      = start & (|pop1);
  assign sb_empty = (occ == '0);
  assign sb_full  = (occ == OCC_W'(SB_DEPTH));
  assign entry0   = {pop0, data_out0};
  assign entry1   = {pop1, data_out1};

  // A same-cycle pop frees a slot, so a push into a full scoreboard still fits.
  // With an empty scoreboard, a coincident ev0/ev1 pair is checked by bypass instead.
  always_comb begin
    do_push       = 1'b0;
    do_pop        = 1'b0;
    do_cmp        = 1'b0;
    set_underflow = 1'b0;
    set_overflow  = 1'b0;
    cmp_ref       = sb_mem[head];
    if (ev1) begin
      if (!sb_empty) begin
        do_pop  = 1'b1;
        do_cmp  = 1'b1;
        do_push = ev0;
      end else if (ev0) begin
        do_cmp  = 1'b1;
        cmp_ref = entry0;
      end else begin
        set_underflow = 1'b1;
      end
    end else if (ev0) begin
      if (sb_full) begin
        set_overflow = 1'b1;
      end else begin
        do_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      sb_mem[tail] <= entry0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      mismatch  <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        tail <= tail + PTR_W'(1);
      end
      if (do_pop) begin
        head <= head + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        occ <= occ + OCC_W'(1);
      end else if (do_pop && !do_push) begin
        occ <= occ - OCC_W'(1);
      end
      if (do_cmp && (entry1 != cmp_ref)) begin
        mismatch <= 1'b1;
      end
      if (set_underflow) begin
        underflow <= 1'b1;
      end
      if (set_overflow) begin
        overflow <= 1'b1;
      end
    end
  end

  assign occupancy = occ;
  assign prop_ok   = ~(mismatch | underflow);

endmodule

// File: doc/out_match_checker.md
OUT_MATCH_CHECKER -- requirements
Module: out_match_checker

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2: requestor count, i.e. the width of each pop vector.
REQ-002 SHALL have parameter WIDTH, default 8: data width per output.
REQ-003 SHALL have parameter SB_DEPTH, default 4: scoreboard entries, a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: checking enable; while low, no captures and no compares occur.
REQ-007 SHALL have port pop0, input, NUM_REQS bits: grant/pop vector from the undelayed copy.
REQ-008 SHALL have port pop1, input, NUM_REQS bits: grant/pop vector from the delayed copy.
REQ-009 SHALL have port data_out0, input, WIDTH bits: data from the undelayed copy, qualified by |pop0.
REQ-010 SHALL have port data_out1, input, WIDTH bits: data from the delayed copy, qualified by |pop1.
REQ-011 SHALL have port prop_ok, output, 1 bit: high while no mismatch and no underflow has occurred.
REQ-012 SHALL have port mismatch, output, 1 bit: sticky flag set when {pop1, data_out1} differs from the expected entry.
REQ-013 SHALL have port underflow, output, 1 bit: sticky flag set when the delayed copy produces an output with nothing expected.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag set when a capture arrives while the scoreboard is full.
REQ-015 SHALL have port occupancy, output, $clog2(SB_DEPTH+1) bits: number of valid scoreboard entries.

Function
REQ-016 Event definitions: ev0 = start & |pop0; ev1 = start & |pop1.
REQ-017 On ev0 with room, the block SHALL write the entry {pop0, data_out0} at the tail; the entry becomes visible to compares from the next cycle.
REQ-018 On ev1 with occupancy > 0, the block SHALL compare {pop1, data_out1} against the head entry and pop the head.
  - Any bit difference SHALL set mismatch on the next edge.
REQ-019 On ev1 with occupancy == 0 and ev0 in the same cycle, the block SHALL compare {pop1, data_out1} directly against {pop0, data_out0} (bypass).
  - The scoreboard SHALL NOT be written and occupancy SHALL remain 0.
REQ-020 On ev1 with occupancy == 0 and no ev0, the block SHALL set underflow; occupancy SHALL remain 0.
REQ-021 With ev0 and ev1 together and occupancy > 0, the block SHALL push and pop in the same cycle.
  - Occupancy SHALL be unchanged.
  - The compare SHALL use the old head.
REQ-022 On ev0 with occupancy == SB_DEPTH and no ev1, the incoming entry SHALL be dropped and overflow set.
  - If ev1 is present, push and pop both proceed and no overflow occurs.
REQ-023 Head and tail pointers SHALL be log2(SB_DEPTH) bits and wrap modulo SB_DEPTH.
  - Occupancy is tracked separately.
  - The full and empty conditions SHALL derive only from occupancy.
REQ-024 mismatch, underflow and overflow SHALL be sticky until rst and SHALL update one cycle after the causing event (registered).
REQ-025 prop_ok SHALL be combinational: ~(mismatch | underflow); overflow SHALL NOT affect prop_ok.
REQ-026 Deasserting start mid-stream SHALL freeze scoreboard contents, pointers and flags until start returns high.
REQ-027 Once set, mismatch SHALL remain set regardless of subsequent matching compares.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL:
  - set head, tail and occupancy to 0;
  - clear mismatch, underflow and overflow to 0;
  - drive prop_ok to 1.
REQ-029 Reset SHALL take priority over any simultaneous ev0/ev1; events in a reset cycle SHALL be ignored.
REQ-030 Scoreboard data storage need not be reset; unread entries SHALL never influence outputs after reset.

Verification
REQ-031 Bench SHALL cover in-order delay, with NUM_REQS=2, WIDTH=8:
  - stimulus: pop0=01, data 0xA5 at cycle 1; pop1=01, data 0xA5 at cycle 3;
  - response: occupancy 1 during cycles 2-3, 0 at cycle 4; prop_ok=1 throughout.
REQ-032 Bench SHALL cover a data mismatch:
  - stimulus: pop0=10, data 0x3C; later pop1=10, data 0x3D;
  - response: mismatch=1 and prop_ok=0 from the following cycle, persisting after later matches.
REQ-033 Bench SHALL cover bypass:
  - stimulus: ev0 and ev1 in the same cycle with occupancy 0 and identical {pop, data};
  - response: occupancy stays 0; no flags set.
REQ-034 Bench SHALL cover overflow:
  - stimulus: SB_DEPTH+1 consecutive ev0 with no ev1;
  - response: occupancy saturates at 4; overflow=1; prop_ok remains 1.
  - follow-up: 4 ev1 with matching data drain occupancy to 0 with no mismatch.
REQ-035 Bench SHALL cover underflow and reset:
  - stimulus: ev1 with empty scoreboard and no ev0;
  - response: underflow=1, prop_ok=0;
  - follow-up: assert rst with concurrent ev0; all flags clear, occupancy 0, and the ev0 is not captured.
